// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI-Lite slave terminating AR/R/AW/W/B onto NUM_REGS
// word registers. Register 0 drives CTRL_OUT; the last register is read-only and
// returns STATUS_IN. Optional build macro AXIL_SLV_ADDR_CHECK_EN rejects addresses
// with bits set outside the register index field (reads return DEAD_BEEF, writes
// are acknowledged without effect); without it the address wraps modulo NUM_REGS.
module axi_lite_slave_regfile #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_LSB  = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [REG_WIDTH-1:0] ARADDR,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [REG_WIDTH-1:0] RDATA,
    output logic                 RVALID,
    input  logic                 RREADY,
    input  logic [REG_WIDTH-1:0] AWADDR,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [REG_WIDTH-1:0] WDATA,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [REG_WIDTH-1:0] CTRL_OUT,
    input  logic [REG_WIDTH-1:0] STATUS_IN,
    output logic                 WR_PULSE
);
    localparam int                   IDX_W    = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]     RO_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [31:0]          BAD_WORD = 32'hDEAD_BEEF;
    localparam logic [REG_WIDTH-1:0] BAD_DATA = REG_WIDTH'(BAD_WORD);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_t;

    // Address legality; without the check every address maps onto some register.
    logic ar_ok;
    logic aw_ok;
`ifdef AXIL_SLV_ADDR_CHECK_EN
    localparam logic [REG_WIDTH-1:0] IDX_MASK = REG_WIDTH'(NUM_REGS - 1) << ADDR_LSB;
    assign ar_ok = (ARADDR & ~IDX_MASK) == '0;
    assign aw_ok = (AWADDR & ~IDX_MASK) == '0;
`else
    assign ar_ok = 1'b1;
    assign aw_ok = 1'b1;
`endif

    // Read path state
    r_state_t               r_state_q, r_state_d;
    logic                   arready_q, arready_d;
    logic [IDX_W-1:0]       r_idx_q,   r_idx_d;
    logic                   r_ok_q,    r_ok_d;
    logic                   rvalid_q,  rvalid_d;
    logic [REG_WIDTH-1:0]   rdata_q,   rdata_d;

    // Write path state
    w_state_t               w_state_q, w_state_d;
    logic                   aw_full_q, aw_full_d;
    logic                   awready_q, awready_d;
    logic [IDX_W-1:0]       aw_idx_q,  aw_idx_d;
    logic                   aw_ok_q,   aw_ok_d;
    logic                   w_full_q,  w_full_d;
    logic                   wready_q,  wready_d;
    logic [REG_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                   bvalid_q,  bvalid_d;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0]   regs_d [NUM_REGS];

    // Read path registers, cleared asynchronously so an in-flight beat is dropped
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            r_idx_q   <= '0;
            r_ok_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            r_idx_q   <= r_idx_d;
            r_ok_q    <= r_ok_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Read next-state: accept, fetch, then hold the beat until the master takes it
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ARVALID) r_state_d = R_ADDR;
            R_ADDR:  r_state_d = R_DATA;
            R_DATA:  if (rvalid_q && RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs; regs_q is sampled before any same-edge write lands
    always_comb begin
        arready_d = 1'b0;
        r_idx_d   = r_idx_q;
        r_ok_d    = r_ok_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    arready_d = 1'b1;
                    r_idx_d   = ARADDR[ADDR_LSB +: IDX_W];
                    r_ok_d    = ar_ok;
                end
            end
            R_ADDR: begin
                rvalid_d = 1'b1;
                if (!r_ok_q)                rdata_d = BAD_DATA;
                else if (r_idx_q == RO_IDX) rdata_d = STATUS_IN;
                else                        rdata_d = regs_q[r_idx_q];
            end
            R_DATA: begin
                if (rvalid_q && RREADY) begin
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Write path registers including the register bank
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q  <= W_COLLECT;
            aw_full_q  <= 1'b0;
            awready_q  <= 1'b0;
            aw_idx_q   <= '0;
            aw_ok_q    <= 1'b0;
            w_full_q   <= 1'b0;
            wready_q   <= 1'b0;
            wdata_q    <= '0;
            bvalid_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_full_q  <= aw_full_d;
            awready_q  <= awready_d;
            aw_idx_q   <= aw_idx_d;
            aw_ok_q    <= aw_ok_d;
            w_full_q   <= w_full_d;
            wready_q   <= wready_d;
            wdata_q    <= wdata_d;
            bvalid_q   <= bvalid_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // Write next-state: commit once both latches hold, release after the B beat
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_COLLECT: if (aw_full_q && w_full_q) w_state_d = W_RESP;
            W_RESP:    if (bvalid_q && BREADY) w_state_d = W_COLLECT;
            default:   w_state_d = W_COLLECT;
        endcase
    end

    // Write outputs: independent AW/W latching, commit, and latch release
    always_comb begin
        aw_full_d  = aw_full_q;
        awready_d  = 1'b0;
        aw_idx_d   = aw_idx_q;
        aw_ok_d    = aw_ok_q;
        w_full_d   = w_full_q;
        wready_d   = 1'b0;
        wdata_d    = wdata_q;
        bvalid_d   = bvalid_q;
        wr_pulse_d = 1'b0;
        regs_d     = regs_q;
        case (w_state_q)
            W_COLLECT: begin
                if (aw_full_q && w_full_q) begin
                    bvalid_d = 1'b1;
                    // The status slot never stores; rejected addresses do not pulse.
                    if (aw_ok_q) begin
                        wr_pulse_d = 1'b1;
                        if (aw_idx_q != RO_IDX) regs_d[aw_idx_q] = wdata_q;
                    end
                end else begin
                    if (AWVALID && !aw_full_q && !awready_q) begin
                        awready_d = 1'b1;
                        aw_full_d = 1'b1;
                        aw_idx_d  = AWADDR[ADDR_LSB +: IDX_W];
                        aw_ok_d   = aw_ok;
                    end
                    if (WVALID && !w_full_q && !wready_q) begin
                        wready_d = 1'b1;
                        w_full_d = 1'b1;
                        wdata_d  = WDATA;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    aw_idx_d  = '0;
                    aw_ok_d   = 1'b0;
                    w_full_d  = 1'b0;
                    wdata_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign WR_PULSE = wr_pulse_q;
    assign CTRL_OUT = regs_q[0];

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: directed AXI-Lite transactions, a cycle-timed
// register-bank model checked against every output on each falling edge, and
// literal expectations on read data and CTRL_OUT.
module tb_axi_lite_slave_regfile;
`ifdef AXIL_SLV_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] ARADDR, AWADDR, WDATA, STATUS_IN;
    logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
    logic        ARREADY, RVALID, AWREADY, WREADY, BVALID, WR_PULSE;
    logic [31:0] RDATA, CTRL_OUT;

    axi_lite_slave_regfile #(.REG_WIDTH(32), .NUM_REGS(8), .ADDR_LSB(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .CTRL_OUT(CTRL_OUT), .STATUS_IN(STATUS_IN), .WR_PULSE(WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scheduled transaction timing, written by the drivers
    int          sb_ar_cyc = -100;
    int          sb_aw_cyc = -100;
    int          sb_w_cyc  = -100;
    logic [31:0] sb_raddr  = '0;
    logic [31:0] sb_waddr  = '0;
    logic [31:0] sb_wdata  = '0;

    // Model state
    logic [31:0] mregs [8];
    logic        m_rvalid = 1'b0, m_bvalid = 1'b0, m_pulse = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          r_done = 1'b0, b_done = 1'b0;
    logic [31:0] rd_val;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return !CHECK_EN || (((a & 32'h3) == 32'h0) && (a < 32'd32));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'd7);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_in_range(a)) return 32'hDEAD_BEEF;
        if (m_idx(a) == 7) return STATUS_IN;
        return mregs[m_idx(a)];
    endfunction

    // Per-cycle comparison of every output against the model
    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                m_rvalid = 1'b0; m_rdata = '0; m_bvalid = 1'b0; m_pulse = 1'b0;
                r_done = 1'b0; b_done = 1'b0;
                for (int i = 0; i < 8; i++) mregs[i] = '0;
                chk1("rst_arready", ARREADY, 1'b0);
                chk1("rst_rvalid", RVALID, 1'b0);
                chk32("rst_rdata", RDATA, 32'h0);
                chk1("rst_awready", AWREADY, 1'b0);
                chk1("rst_wready", WREADY, 1'b0);
                chk1("rst_bvalid", BVALID, 1'b0);
                chk1("rst_wr_pulse", WR_PULSE, 1'b0);
                chk32("rst_ctrl_out", CTRL_OUT, 32'h0);
            end else begin
                m_pulse = 1'b0;
                if (r_done) begin m_rvalid = 1'b0; m_rdata = '0; r_done = 1'b0; end
                if (b_done) begin m_bvalid = 1'b0; b_done = 1'b0; end
                // Read data is taken before a write landing on the same edge
                if (cyc == sb_ar_cyc + 2) begin
                    m_rvalid = 1'b1;
                    m_rdata  = m_read(sb_raddr);
                end
                if (cyc == ((sb_aw_cyc > sb_w_cyc) ? sb_aw_cyc : sb_w_cyc) + 2) begin
                    m_bvalid = 1'b1;
                    if (m_in_range(sb_waddr)) begin
                        m_pulse = 1'b1;
                        if (m_idx(sb_waddr) != 7) mregs[m_idx(sb_waddr)] = sb_wdata;
                    end
                end
                chk1("arready", ARREADY, cyc == sb_ar_cyc + 1);
                chk1("rvalid", RVALID, m_rvalid);
                chk32("rdata", RDATA, m_rdata);
                chk1("awready", AWREADY, cyc == sb_aw_cyc + 1);
                chk1("wready", WREADY, cyc == sb_w_cyc + 1);
                chk1("bvalid", BVALID, m_bvalid);
                chk1("wr_pulse", WR_PULSE, m_pulse);
                chk32("ctrl_out", CTRL_OUT, mregs[0]);
                if (m_rvalid && RREADY) r_done = 1'b1;
                if (m_bvalid && BREADY) b_done = 1'b1;
            end
        end
    end

    // Write: AW raised aw_dly cycles after start, W after w_dly; each VALID stays
    // up through its READY cycle plus 'extra' cycles. resp=0 leaves BVALID pending.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                      input int w_dly, input int extra, input bit resp);
        int  t0, last;
        bit  seen;
        @(posedge ACLK); #1;
        t0 = cyc;
        sb_waddr  = addr;
        sb_wdata  = data;
        sb_aw_cyc = t0 + aw_dly;
        sb_w_cyc  = t0 + w_dly;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        AWADDR = addr;
        WDATA  = data;
        for (int i = 0; i <= last + 1 + extra; i++) begin
            AWVALID = (i >= aw_dly) && (i <= aw_dly + 1 + extra);
            WVALID  = (i >= w_dly) && (i <= w_dly + 1 + extra);
            @(posedge ACLK); #1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (BVALID) begin seen = 1'b1; break; end
        end
        chk1("bvalid_seen", seen, 1'b1);
        if (resp) begin
            @(posedge ACLK); #1; BREADY = 1'b1;
            @(posedge ACLK); #1; BREADY = 1'b0;
        end
    endtask

    // Read: ARVALID up through its READY cycle plus 'extra'; take=0 leaves RVALID pending.
    task automatic rd(input logic [31:0] addr, input int extra, input bit take,
                      output logic [31:0] data);
        bit seen;
        @(posedge ACLK); #1;
        sb_ar_cyc = cyc;
        sb_raddr  = addr;
        ARADDR  = addr;
        ARVALID = 1'b1;
        repeat (2 + extra) begin @(posedge ACLK); #1; end
        ARVALID = 1'b0;
        seen = 1'b0;
        data = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (RVALID) begin seen = 1'b1; break; end
        end
        chk1("rvalid_seen", seen, 1'b1);
        data = RDATA;
        if (take) begin
            @(posedge ACLK); #1; RREADY = 1'b1;
            @(posedge ACLK); #1; RREADY = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        ARESETN = 1'b1;
        ARVALID = 1'b0; RREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; AWADDR = '0; WDATA = '0;
        STATUS_IN = 32'hA5A5_0001;
        #1 ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;

        // Reset contents of every index
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 4), 0, 1'b1, rd_val);
            chk32("reset_readback", rd_val, (i == 7) ? 32'hA5A5_0001 : 32'h0);
        end

        // CTRL_OUT via AW-first, simultaneous (VALIDs held long), and W-first
        wr(32'h0, 32'h1234_5678, 0, 1, 0, 1'b1);
        chk32("ctrl_aw_first", CTRL_OUT, 32'h1234_5678);
        wr(32'h0, 32'hCAFE_0000, 0, 0, 1, 1'b1);
        chk32("ctrl_same_cycle", CTRL_OUT, 32'hCAFE_0000);
        wr(32'h0, 32'h1234_5678, 1, 0, 0, 1'b1);
        chk32("ctrl_w_first", CTRL_OUT, 32'h1234_5678);

        // Read-only status register
        wr(32'h1C, 32'hFFFF_FFFF, 0, 0, 0, 1'b1);
        rd(32'h1C, 0, 1'b1, rd_val);
        chk32("ro_readback", rd_val, 32'hA5A5_0001);
        STATUS_IN = 32'h1357_9BDF;
        rd(32'h1C, 1, 1'b1, rd_val);
        chk32("status_live", rd_val, 32'h1357_9BDF);

        // Same-edge read and write of one index
        wr(32'h4, 32'h0000_0055, 0, 0, 0, 1'b1);
        fork
            wr(32'h4, 32'h0000_00AA, 0, 0, 0, 1'b1);
            rd(32'h4, 0, 1'b1, rd_val);
        join
        chk32("collision_old", rd_val, 32'h0000_0055);
        rd(32'h4, 1, 1'b1, rd_val);
        chk32("collision_new", rd_val, 32'h0000_00AA);

        // Address outside the index field
        rd(32'h24, 0, 1'b1, rd_val);
        chk32("addr24_read", rd_val, CHECK_EN ? 32'hDEAD_BEEF : 32'h0000_00AA);
        wr(32'h24, 32'h0000_0BAD, 0, 0, 0, 1'b1);
        rd(32'h4, 0, 1'b1, rd_val);
        chk32("addr24_write", rd_val, CHECK_EN ? 32'h0000_00AA : 32'h0000_0BAD);
        rd(32'h6, 0, 1'b1, rd_val);
        chk32("misaligned_read", rd_val, CHECK_EN ? 32'hDEAD_BEEF : 32'h0000_0BAD);

        // Reset with an R beat and a B beat both outstanding
        fork
            wr(32'h8, 32'h0F0F_0F0F, 0, 0, 0, 1'b0);
            rd(32'h0, 0, 1'b0, rd_val);
        join
        chk32("pending_rdata", rd_val, 32'h1234_5678);
        @(posedge ACLK); #2;
        ARESETN   = 1'b0;
        sb_ar_cyc = -100;
        sb_aw_cyc = -100;
        sb_w_cyc  = -100;
        #1;
        chk1("async_rvalid", RVALID, 1'b0);
        chk1("async_bvalid", BVALID, 1'b0);
        chk32("async_rdata", RDATA, 32'h0);
        chk32("async_ctrl", CTRL_OUT, 32'h0);
        chk1("async_arready", ARREADY, 1'b0);
        chk1("async_wr_pulse", WR_PULSE, 1'b0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (6) @(posedge ACLK);
        rd(32'h8, 0, 1'b1, rd_val);
        chk32("post_reset_reg2", rd_val, 32'h0);
        rd(32'h0, 0, 1'b1, rd_val);
        chk32("post_reset_reg0", rd_val, 32'h0);
        repeat (3) @(posedge ACLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

AXI-Lite slave that terminates the five channels driven by the team's AXI-Lite master interface and maps them onto a bank of NUM_REGS word-addressed registers. Register 0 is driven out as a control word. The last register is a read-only status word sampled from fabric logic. The block sits directly downstream of the master on the same ACLK domain, with no CDC.

## Interface
- REG_WIDTH, 32, data and address width of all channels
- NUM_REGS, 8, register count; power of two, minimum 2
- ADDR_LSB, 2, byte-address bits dropped before indexing; index = ADDR[ADDR_LSB +: log2(NUM_REGS)]

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- ARADDR  in  REG_WIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address accept pulse
- RDATA  out  REG_WIDTH  read data
- RVALID  out  1  read data valid
- RREADY  in  1  master ready for read data
- AWADDR  in  REG_WIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address accept pulse
- WDATA  in  REG_WIDTH  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data accept pulse
- BVALID  out  1  write response valid
- BREADY  in  1  master ready for response
- CTRL_OUT  out  REG_WIDTH  live contents of register 0
- STATUS_IN  in  REG_WIDTH  value returned for register NUM_REGS-1
- WR_PULSE  out  1  one-cycle strobe on each committed write

## Operation
- Reset: ARREADY, RVALID, RDATA, AWREADY, WREADY, BVALID, WR_PULSE and all registers are 0. CTRL_OUT is therefore 0. Address and data latches are cleared.
- Read FSM states are R_IDLE, R_ADDR and R_DATA.
  - R_IDLE -> R_ADDR when ARVALID=1. ARREADY=1 for exactly that one R_ADDR cycle, and the index is captured from ARADDR.
  - R_ADDR -> R_DATA unconditionally. RDATA is loaded and RVALID=1.
  - R_DATA holds RVALID and RDATA stable until RVALID&&RREADY is sampled. It then -> R_IDLE with RVALID=0 and RDATA=0.
- Write path: the AW and W latches fill independently, in either order or in the same cycle.
  - AWREADY pulses for one cycle when AWVALID=1, the AW latch is empty and AWREADY=0. The AW address is latched on that edge.
  - WREADY follows the same rule with WVALID and the W latch.
- Write states are W_COLLECT and W_RESP.
  - W_COLLECT -> W_RESP on the edge after both latches are full. On that edge the register is written, BVALID=1 and WR_PULSE=1 (one cycle).
  - W_RESP holds BVALID until BVALID&&BREADY is sampled. It then clears BVALID and both latches and -> W_COLLECT.
  - No new AWREADY or WREADY is issued while in W_RESP.
- Register NUM_REGS-1 is read-only. A read of it returns STATUS_IN as sampled on the R_ADDR->R_DATA edge. A write to it still completes the handshake and pulses WR_PULSE, but changes no state.
- Read/write collision on the same index in the same edge: the read returns the pre-write value.
- Address index width is log2(NUM_REGS). Bits above the index are handled per Configuration.

## Timing
- Read: ARVALID sampled high at edge N gives ARREADY high in cycle N+1. RVALID rises at N+2. RVALID falls on the edge after RREADY is sampled high. Minimum turnaround with the team master is 4 cycles.
- Write: both VALIDs sampled high at edge N give both READYs high in cycle N+1. Register update, BVALID and WR_PULSE follow at N+2. Write-to-CTRL_OUT latency is 2 cycles from the final VALID.
- A READY is never asserted for two consecutive cycles. The master's VALID may stay high for one cycle after READY, and that cycle must not trigger a second accept. Each latch accepts again only after the W_RESP -> W_COLLECT transition.
- Read and write paths are fully concurrent.
- ARESETN assertion mid-transaction clears all state asynchronously. The in-flight transaction is dropped and no B or R beat is produced.

## Configuration
- AXIL_SLV_ADDR_CHECK_EN defined:
  - Address bits above the index, or bits below ADDR_LSB, must be zero.
  - Out-of-range writes complete the handshake (BVALID) with no register change and no WR_PULSE.
  - Out-of-range reads return 32'hDEAD_BEEF, truncated to REG_WIDTH.
- Not defined: upper and lower bits are ignored, and the address wraps modulo NUM_REGS.

## Test plan
- Reset then read each index: returns 0 for indices 0..NUM_REGS-2, and STATUS_IN=32'hA5A5_0001 for index 7. ARREADY is exactly one cycle per read.
- Write 32'h1234_5678 to 0x0 with AW one cycle before W, and with W before AW: CTRL_OUT=32'h1234_5678 two cycles after the later VALID. WR_PULSE fires once and BVALID clears after BREADY.
- Write 32'hFFFF_FFFF to 0x1C (read-only register): BVALID is returned. A readback of 0x1C shows STATUS_IN, not the written value.
- Same-edge write of 32'h0000_00AA to 0x4 and read of 0x4, where the register previously held 0x55: RDATA=0x55 and a subsequent read returns 0xAA.
- Address 0x24 in both builds:
  - With AXIL_SLV_ADDR_CHECK_EN: a read returns 32'hDEAD_BEEF, a write changes no register, and WR_PULSE stays low.
  - Without it: the access aliases to index 1.
- Assert ARESETN low while RVALID=1 and BVALID pending: all outputs are 0 within the same cycle, and no further RVALID or BVALID appears after release.
